// File: rtl/seq_wide_adder_ctrl.sv
// Multi-cycle wide adder: walks TOTAL_WIDTH-bit operands LSB chunk first through one shared
// CHUNK_WIDTH-bit square-root carry-select adder. Optional subtract mode under SEQ_ADD_SUB_EN.
module seq_wide_adder_ctrl #(
  parameter int unsigned TOTAL_WIDTH = 64,
  parameter int unsigned CHUNK_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] a,
  input  logic [TOTAL_WIDTH-1:0] b,
  input  logic                   cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic                   op_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int unsigned NumChunks = TOTAL_WIDTH / CHUNK_WIDTH;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [TOTAL_WIDTH-1:0] a_q, a_d;
  logic [TOTAL_WIDTH-1:0] b_q, b_d;
  logic [TOTAL_WIDTH-1:0] sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
  logic [IdxW-1:0]        idx_q, idx_d;

  logic [CHUNK_WIDTH-1:0] add_a, add_b, add_sum;
  logic                   add_cout;

  assign add_a = a_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign add_b = b_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];

  // Carry-select blocks of growing length (1, 2, 3, ...): each block ripples both carry-in
  // hypotheses and the incoming block carry picks one.
  always_comb begin
    logic        c0, c1, blk_c;
    int unsigned pos, len;
    add_sum = '0;
    blk_c   = carry_q;
    c0      = 1'b0;
    c1      = 1'b1;
    pos     = 0;
    len     = 1;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (pos == 0) begin
        c0 = 1'b0;
        c1 = 1'b1;
      end
      add_sum[i] = blk_c ? (add_a[i] ^ add_b[i] ^ c1) : (add_a[i] ^ add_b[i] ^ c0);
      c0 = (add_a[i] & add_b[i]) | (c0 & (add_a[i] ^ add_b[i]));
      c1 = (add_a[i] & add_b[i]) | (c1 & (add_a[i] ^ add_b[i]));
      pos++;
      if (pos == len) begin
        blk_c = blk_c ? c1 : c0;
        pos   = 0;
        len++;
      end
    end
    add_cout = (pos == 0) ? blk_c : (blk_c ? c1 : c0);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
`ifdef SEQ_ADD_SUB_EN
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        sum_d[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = add_sum;
        carry_d = add_cout;
        if (idx_q == LastIdx) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Bench for seq_wide_adder_ctrl: cycle-level behavioural model (age counter + plain arithmetic)
// checked every cycle, plus literal directed cases. Subtract cases under SEQ_ADD_SUB_EN.
module tb_seq_wide_adder_ctrl;

  localparam int TW = 64;
  localparam int CW = 16;
  localparam int NC = TW / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a, b;
  logic          cin;
`ifdef SEQ_ADD_SUB_EN
  logic          op_sub;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          cout;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model: m_age < 0 means idle; 0..NC-1 while chunks are being added; NC means result held.
  int          m_age = -1;
  logic [TW:0] m_res = '0;
  logic [TW:0] m_shown = '0;

  seq_wide_adder_ctrl #(
    .TOTAL_WIDTH(TW),
    .CHUNK_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SEQ_ADD_SUB_EN
    .op_sub   (op_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [TW:0] act, input logic [TW:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] rnd64();
    logic [TW-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = '0;
      2: v = v | 64'hFFFF_0000_FFFF_0000;
      default: ;
    endcase
    return v;
  endfunction

  // Advance one clock: predict next model state from current inputs, then step.
  task automatic cycle();
    int          n_age   = m_age;
    logic [TW:0] n_res   = m_res;
    logic [TW:0] n_shown = m_shown;
    logic        sub_sel = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    sub_sel = op_sub;
`endif
    if (rst) begin
      n_age   = -1;
      n_shown = '0;
    end else if (m_age < 0) begin
      if (in_valid) begin
        n_age = 0;
        n_res = sub_sel ? ({1'b0, a} + {1'b0, ~b} + 65'd1)
                        : ({1'b0, a} + {1'b0, b} + {64'd0, cin});
      end
    end else if (m_age < NC) begin
      n_age = m_age + 1;
      if (n_age == NC) n_shown = m_res;
    end else if (out_ready) begin
      n_age = -1;
    end
    @(posedge clk);
    m_age   = n_age;
    m_res   = n_res;
    m_shown = n_shown;
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", {64'd0, in_ready}, {64'd0, (m_age < 0)});
      chk("out_valid", {64'd0, out_valid}, {64'd0, (m_age == NC)});
      chk("busy", {64'd0, busy}, {64'd0, (m_age >= 0)});
      if (m_age < 0 || m_age == NC) begin
        chk("sum", {1'b0, sum}, {1'b0, m_shown[TW-1:0]});
        chk("cout", {64'd0, cout}, {64'd0, m_shown[TW]});
      end
    end
  end

  task automatic run_op(input logic [TW-1:0] ta, input logic [TW-1:0] tb_, input logic tc,
                        input logic [TW-1:0] es, input logic ec);
    int lat = 0;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    a = rnd64(); b = rnd64(); cin = ~tc;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk("latency", 65'(lat), 65'(NC));
    chk("dir_sum", {1'b0, sum}, {1'b0, es});
    chk("dir_cout", {64'd0, cout}, {64'd0, ec});
    cycle();
    chk("in_ready_after", {64'd0, in_ready}, 65'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    op_sub = 1'b0;
`endif
    cycle();
    cycle();
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_in_ready", {64'd0, in_ready}, 65'd1);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_sum", {1'b0, sum}, 65'd0);
    chk("rst_cout", {64'd0, cout}, 65'd0);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
    run_op(64'h0000_1234_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1,
           64'h0000_1235_0001_0001, 1'b0);

    // Consumer stall with new requests arriving while the result is held.
    a = 64'd100; b = 64'd23; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    for (int i = 0; i < 10; i++) begin
      a = rnd64(); b = rnd64();
      cycle();
      chk("stall_valid", {64'd0, out_valid}, 65'd1);
      chk("stall_sum", {1'b0, sum}, 65'd123);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("release_in_ready", {64'd0, in_ready}, 65'd1);

    // Reset two cycles into an operation aborts it.
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h1; cin = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("abort_out_valid", {64'd0, out_valid}, 65'd0);
    chk("abort_sum", {1'b0, sum}, 65'd0);
    chk("abort_cout", {64'd0, cout}, 65'd0);
    chk("abort_in_ready", {64'd0, in_ready}, 65'd1);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd1, 1'b1);

    // Back-to-back: operands change only after each accept.
    begin
      int ops = 0;
      a = 64'd1; b = 64'd2; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 40 && ops < 3; i++) begin
        logic acc;
        acc = in_ready;
        cycle();
        if (acc) begin
          ops++;
          a = a + 64'd10; b = {$urandom, $urandom};
        end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !in_ready; i++) cycle();
      chk("b2b_ops", 65'(ops), 65'd3);
    end

`ifdef SEQ_ADD_SUB_EN
    op_sub = 1'b1;
    run_op(64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op(64'd7, 64'd5, 1'b1, 64'd2, 1'b1);
    op_sub = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = rnd64();
      b   = rnd64();
      cin = 1'($urandom);
`ifdef SEQ_ADD_SUB_EN
      op_sub = 1'($urandom);
`endif
      cycle();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
